dds_wave_gen: RTL

DDS_WAVE_GEN -- requirements
Module: dds_wave_gen

---
 rtl/dds_wave_gen.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/dds_wave_gen.sv
// dds_wave_gen -- direct digital synthesis waveform generator.
//
// A phase accumulator advances by a frequency word on every clock while
// running. The accumulator plus a phase offset addresses a waveform
// function (saw, triangle, square or zero), and the result is registered
// as a signed two's-complement sample. A new configuration offered while
// running is held in a one-entry shadow. It becomes active only at a
// phase wrap, so a running waveform is never torn mid-period.
//
// Ports
//   sys_clk      in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   run          in   level request to generate samples
//   cfg_valid    in   configuration offer
//   cfg_ready    out  configuration can be accepted (shadow empty)
//   freq_word    in   ACC_BIT per-clock phase increment
//   phase_word   in   ACC_BIT phase offset
//   wave_sel     in   0 saw, 1 triangle, 2 square, 3 zero
//   dds_data     out  DATA_BIT signed sample, registered
//   dds_data_en  out  dds_data valid this cycle, registered
//   busy         out  high while running or finishing the last period
module dds_wave_gen #(
  parameter int DATA_BIT = 14,
  parameter int ACC_BIT  = 32   // must be at least DATA_BIT+1
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ACC_BIT-1:0]  freq_word,
  input  logic [ACC_BIT-1:0]  phase_word,
  input  logic [1:0]          wave_sel,
  output logic [DATA_BIT-1:0] dds_data,
  output logic                dds_data_en,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOP_PEND
  } state_e;

  localparam logic [1:0] SEL_SAW    = 2'd0;
  localparam logic [1:0] SEL_TRI    = 2'd1;
  localparam logic [1:0] SEL_SQUARE = 2'd2;

  localparam logic [DATA_BIT-1:0] SQ_POS = {1'b0, {(DATA_BIT-1){1'b1}}};
  localparam logic [DATA_BIT-1:0] SQ_NEG = {1'b1, {(DATA_BIT-1){1'b0}}};

  state_e              state_q;
  logic [ACC_BIT-1:0]  acc_q;
  logic [ACC_BIT-1:0]  freq_q;
  logic [ACC_BIT-1:0]  phase_q;
  logic [1:0]          sel_q;
  logic [ACC_BIT-1:0]  sh_freq_q;
  logic [ACC_BIT-1:0]  sh_phase_q;
  logic [1:0]          sh_sel_q;
  logic                pending_q;
  logic [DATA_BIT-1:0] data_q;
  logic                data_en_q;

  logic [ACC_BIT:0]    acc_sum;
  logic                wrap;
  logic                freq_zero;
  logic                generating;
  logic                accept;
  logic                apply_shadow;
  logic [ACC_BIT-1:0]  pa;
  logic [DATA_BIT-1:0] p;
  logic [DATA_BIT-1:0] t;
  logic [DATA_BIT-1:0] wave_d;

  // Accumulator step and the events derived from it. The extra sum bit is
  // the carry out that marks the end of a waveform period.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no
    // latch is inferred.
    acc_sum      = {1'b0, acc_q} + {1'b0, freq_q};
    wrap         = acc_sum[ACC_BIT];
    freq_zero    = (freq_q == '0);
    generating   = (state_q != ST_IDLE);
    accept       = cfg_valid & ~pending_q;
    // With a zero step the accumulator would never wrap, so a pending
    // shadow is applied immediately instead of waiting forever.
    apply_shadow = generating & pending_q & (wrap | freq_zero);
  end

  // Waveform lookup on the pre-update accumulator plus phase offset.
  always_comb begin
    pa = acc_q + phase_q;
    p  = pa[ACC_BIT-1 -: DATA_BIT];
    // Triangle: one bit finer than the saw, folded in the second half of
    // the period so the ramp runs back down.
    t  = pa[ACC_BIT-2 -: DATA_BIT];
    if (pa[ACC_BIT-1]) t = ~t;
    case (sel_q)
      SEL_SAW:    wave_d = {~p[DATA_BIT-1], p[DATA_BIT-2:0]};
      SEL_TRI:    wave_d = {~t[DATA_BIT-1], t[DATA_BIT-2:0]};
      SEL_SQUARE: wave_d = pa[ACC_BIT-1] ? SQ_NEG : SQ_POS;
      default:    wave_d = '0;
    endcase
  end

  // Phase bits below the triangle resolution only matter through the
  // carries they feed into the upper bits.
  if (ACC_BIT > DATA_BIT + 1) begin : g_pa_low
    logic unused_pa_low;
    assign unused_pa_low = ^pa[ACC_BIT-DATA_BIT-2:0];
  end

  // Control FSM, accumulator and registered sample outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      data_q    <= '0;
      data_en_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          data_q    <= '0;
          data_en_q <= 1'b0;
          if (run) begin
            acc_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q     <= acc_sum[ACC_BIT-1:0];
          data_q    <= wave_d;
          data_en_q <= 1'b1;
          if (!run) state_q <= ST_STOP_PEND;
        end
        ST_STOP_PEND: begin
          // Keep generating until the period completes, so a stop never
          // truncates a waveform cycle.
          acc_q     <= acc_sum[ACC_BIT-1:0];
          data_q    <= wave_d;
          data_en_q <= 1'b1;
          if (run)                    state_q <= ST_RUN;
          else if (wrap || freq_zero) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Active and shadow configuration. Accept requires an empty shadow and
  // apply requires a full one, so the two never happen on the same edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_q     <= '0;
      phase_q    <= '0;
      sel_q      <= '0;
      sh_freq_q  <= '0;
      sh_phase_q <= '0;
      sh_sel_q   <= '0;
      pending_q  <= 1'b0;
    end else if (!generating) begin
      if (accept) begin
        freq_q  <= freq_word;
        phase_q <= phase_word;
        sel_q   <= wave_sel;
      end
    end else begin
      if (apply_shadow) begin
        freq_q    <= sh_freq_q;
        phase_q   <= sh_phase_q;
        sel_q     <= sh_sel_q;
        pending_q <= 1'b0;
      end
      if (accept) begin
        sh_freq_q  <= freq_word;
        sh_phase_q <= phase_word;
        sh_sel_q   <= wave_sel;
        pending_q  <= 1'b1;
      end
    end
  end

  assign cfg_ready   = ~pending_q;
  assign busy        = generating;
  assign dds_data    = data_q;
  assign dds_data_en = data_en_q;

endmodule
